spatial_accumulator: RTL and testbench
======================================

// Module: spatial_accumulator
// PURPOSE
//  Spatial bundling stage of the HD encoder. It collects one bipolar hypervector per
//  channel, weighted by that channel's feature magnitude, into per-dimension signed
//  sums, and outputs their binarised sign. It sits between the item-memory/binding
//  stage and the temporal encoder. FirstHypervector_SI starts a new sum.
// PARAMETERS
//  HV_DIMENSION   `HV_DIMENSION (10000)  hypervector width; bit 0 is the MSB ([0:D-1])
//  CHANNEL_WIDTH  `CHANNEL_WIDTH (6)     feature magnitude width, unsigned
//  ACC_WIDTH      CHANNEL_WIDTH+7 (13)   signed per-dimension accumulator width
// PORTS
//  Clk_CI               in   1              clock; all state changes on rising edge
//  Reset_RI             in   1              synchronous, active-high reset
//  Enable_SI            in   1              accept HypervectorIn_DI/FeatureIn_DI this cycle
//  FirstHypervector_SI  in   1              this input starts a new sum (load, not add)
//  HypervectorIn_DI     in   HV_DIMENSION   binary HV; bit=1 means +1, bit=0 means -1
//  FeatureIn_DI         in   CHANNEL_WIDTH  unsigned weight applied to HypervectorIn_DI
//  HypervectorOut_DO    out  HV_DIMENSION   per-dimension sign of the accumulator
// BEHAVIOUR
//  - State: acc[i] for i in 0..D-1, each ACC_WIDTH two's complement.
//    term[i] = HypervectorIn_DI[i] ? +FeatureIn_DI : -FeatureIn_DI (zero-extended, then signed).
//  - Rising edge, in priority order:
//    Reset_RI=1                 -> every acc[i] = 0
//    Enable_SI=0                -> hold; FirstHypervector_SI is ignored
//    Enable_SI=1 and First=1    -> acc[i] = term[i], discarding the previous sum
//    Enable_SI=1 and First=0    -> acc[i] = sat(acc[i] + term[i])
//  - sat() clamps to +/-(2^(ACC_WIDTH-1)-1) = +/-4095. Accumulators never wrap.
//  - HypervectorOut_DO[i] = (acc[i] > 0). It is combinational from the registers, so the
//    result appears one cycle after the accepting edge. A tie (acc==0) gives 0.
//  - Reset value: all acc = 0, so HypervectorOut_DO = all zeros.
//  - FeatureIn_DI=0 with Enable_SI=1 adds 0; with First=1 it loads 0 everywhere.
//  - Reset asserted mid-sum clears the state immediately. The next sum may begin with
//    First=0; it then accumulates onto 0.
//  - No handshake or backpressure: one input is accepted per enabled cycle, and
//    there is no internal channel counter.
// STRUCTURE
//  - Shared package/header (const.vh): HV_DIMENSION, CHANNEL_WIDTH, ACC_WIDTH.
//  - Sub-module spatial_acc_cell: one dimension, with inputs bit, feature, enable, first,
//    reset. It holds a signed saturating accumulator and drives its sign output.
//    The top level instantiates it HV_DIMENSION times with a generate loop.
// TESTING  (bench instance HV_DIMENSION=10, CHANNEL_WIDTH=6)
//  1 Reset one cycle -> HypervectorOut_DO=0000000000 and every acc=0.
//  2 En=1,First=1,HV=1010101010,F=1 -> out=1010101010 (acc=+1/-1).
//    Then First=0, same HV, with F=2,3,4,5 on successive cycles -> out stays 1010101010.
//    Even-index acc=+15, odd-index acc=-15.
//  3 First: HV=1010101010,F=1. Then HV=0101010101,F=2 -> out=0101010101 (acc=-1/+1).
//  4 First: HV=1111111111,F=3. Then HV=0000000000,F=3 -> acc=0, so out=0000000000 (tie).
//  5 En=0 with First=1 and any HV/F -> out and acc unchanged.
//    Then En=1,First=1 -> previous sum discarded, out equals the new HV.
//  6 HV=all-ones,F=63 for 70 enabled cycles -> acc saturates at +4095 with no wrap.
//    Then Reset mid-stream -> out=0000000000 on the next cycle.

Source files
------------

// File: rtl/spatial_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spatial_accumulator_pkg
// Purpose  : Shared widths for the spatial bundling stage of the HD encoder.
// Revision : 1.0 - initial release
// ============================================================================
package spatial_accumulator_pkg;

  localparam int unsigned c_HV_DIMENSION  = 10000;
  localparam int unsigned c_CHANNEL_WIDTH = 6;
  localparam int unsigned c_ACC_WIDTH     = c_CHANNEL_WIDTH + 7;

endpackage : spatial_accumulator_pkg
`default_nettype wire

// File: rtl/spatial_acc_cell.sv
`default_nettype none
// ============================================================================
// Module   : spatial_acc_cell
// Purpose  : One hypervector dimension: signed saturating weighted accumulator
//            with a registered sum and a combinational sign output.
// Revision : 1.0 - initial release
// ============================================================================
module spatial_acc_cell
  import spatial_accumulator_pkg::*;
#(
  parameter int unsigned CHANNEL_WIDTH = c_CHANNEL_WIDTH,
  parameter int unsigned ACC_WIDTH     = c_ACC_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_enable,
  input  logic                     i_first,
  input  logic                     i_bit,
  input  logic [CHANNEL_WIDTH-1:0] i_feature,
  output logic                     o_sign
);

  // One extra bit of headroom so the sum can be compared before clamping.
  localparam logic signed [ACC_WIDTH:0] c_SUM_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] c_SUM_MIN = -c_SUM_MAX;
  localparam logic [ACC_WIDTH-1:0]      c_ACC_MAX = c_SUM_MAX[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0]      c_ACC_MIN = c_SUM_MIN[ACC_WIDTH-1:0];

  logic        [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH:0]   w_mag;
  logic signed [ACC_WIDTH:0]   w_term;
  logic signed [ACC_WIDTH:0]   w_sum;
  logic        [ACC_WIDTH-1:0] w_next;

  assign w_mag  = $signed({{(ACC_WIDTH+1-CHANNEL_WIDTH){1'b0}}, i_feature});
  assign w_term = i_bit ? w_mag : -w_mag;
  assign w_sum  = $signed({r_acc[ACC_WIDTH-1], r_acc}) + w_term;

  always_comb begin
    w_next = w_sum[ACC_WIDTH-1:0];
    if (i_first) begin
      w_next = w_term[ACC_WIDTH-1:0];
    end else if (w_sum > c_SUM_MAX) begin
      w_next = c_ACC_MAX;
    end else if (w_sum < c_SUM_MIN) begin
      w_next = c_ACC_MIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_enable) begin
      r_acc <= w_next;
    end
  end

  // Strictly positive: a zero sum (tie) binarises to 0.
  assign o_sign = !r_acc[ACC_WIDTH-1] && (r_acc != '0);

endmodule : spatial_acc_cell
`default_nettype wire

// File: rtl/spatial_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : spatial_accumulator
// Purpose  : Bundles weighted bipolar channel hypervectors into per-dimension
//            saturating sums and outputs their binarised sign.
// Revision : 1.0 - initial release
// ============================================================================
module spatial_accumulator
  import spatial_accumulator_pkg::*;
#(
  parameter int unsigned HV_DIMENSION  = c_HV_DIMENSION,
  parameter int unsigned CHANNEL_WIDTH = c_CHANNEL_WIDTH,
  parameter int unsigned ACC_WIDTH     = CHANNEL_WIDTH + 7
) (
  input  logic                     Clk_CI,
  input  logic                     Reset_RI,
  input  logic                     Enable_SI,
  input  logic                     FirstHypervector_SI,
  input  logic [0:HV_DIMENSION-1]  HypervectorIn_DI,
  input  logic [CHANNEL_WIDTH-1:0] FeatureIn_DI,
  output logic [0:HV_DIMENSION-1]  HypervectorOut_DO
);

  for (genvar i = 0; i < HV_DIMENSION; i++) begin : g_cell
    spatial_acc_cell #(
      .CHANNEL_WIDTH (CHANNEL_WIDTH),
      .ACC_WIDTH     (ACC_WIDTH)
    ) u_cell (
      .clk       (Clk_CI),
      .rst       (Reset_RI),
      .i_enable  (Enable_SI),
      .i_first   (FirstHypervector_SI),
      .i_bit     (HypervectorIn_DI[i]),
      .i_feature (FeatureIn_DI),
      .o_sign    (HypervectorOut_DO[i])
    );
  end : g_cell

endmodule : spatial_accumulator
`default_nettype wire

// File: tb/tb_spatial_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_spatial_accumulator
// Purpose  : Self-checking bench for spatial_accumulator against an integer
//            reference model of the weighted, saturating bundling rule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spatial_accumulator;

  localparam int D  = 10;
  localparam int CW = 6;
  localparam int SAT = 4095;

  logic          Clk_CI = 1'b0;
  logic          Reset_RI = 1'b0;
  logic          Enable_SI = 1'b0;
  logic          FirstHypervector_SI = 1'b0;
  logic [0:D-1]  HypervectorIn_DI = '0;
  logic [CW-1:0] FeatureIn_DI = '0;
  logic [0:D-1]  HypervectorOut_DO;

  int errors = 0;
  int checks = 0;
  int m_acc [D];

  spatial_accumulator #(
    .HV_DIMENSION  (D),
    .CHANNEL_WIDTH (CW)
  ) dut (
    .Clk_CI              (Clk_CI),
    .Reset_RI            (Reset_RI),
    .Enable_SI           (Enable_SI),
    .FirstHypervector_SI (FirstHypervector_SI),
    .HypervectorIn_DI    (HypervectorIn_DI),
    .FeatureIn_DI        (FeatureIn_DI),
    .HypervectorOut_DO   (HypervectorOut_DO)
  );

  always #5 Clk_CI = ~Clk_CI;

  function automatic logic [0:D-1] exp_out();
    logic [0:D-1] r;
    for (int i = 0; i < D; i++) r[i] = (m_acc[i] > 0);
    return r;
  endfunction

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic step(input logic rst, input logic en, input logic first,
                      input logic [0:D-1] hv, input logic [CW-1:0] f);
    int t;
    Reset_RI            = rst;
    Enable_SI           = en;
    FirstHypervector_SI = first;
    HypervectorIn_DI    = hv;
    FeatureIn_DI        = f;
    @(posedge Clk_CI);
    for (int i = 0; i < D; i++) begin
      t = hv[i] ? int'(f) : -int'(f);
      if (rst) m_acc[i] = 0;
      else if (en && first) m_acc[i] = t;
      else if (en) begin
        m_acc[i] = m_acc[i] + t;
        if (m_acc[i] > SAT) m_acc[i] = SAT;
        if (m_acc[i] < -SAT) m_acc[i] = -SAT;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, '0, '0);
    checks++;
    if (HypervectorOut_DO !== 10'b0000000000) begin
      errors++;
      $display("FAIL reset: got %b expected %b", HypervectorOut_DO, 10'b0);
    end
  endtask

  task automatic test_accumulate();
    step(1'b0, 1'b1, 1'b1, 10'b1010101010, 6'd1);
    checks++;
    if (HypervectorOut_DO !== 10'b1010101010) begin
      errors++;
      $display("FAIL accum_first: got %b expected %b", HypervectorOut_DO, 10'b1010101010);
    end
    for (int f = 2; f <= 5; f++) begin
      step(1'b0, 1'b1, 1'b0, 10'b1010101010, CW'(f));
      checks++;
      if (HypervectorOut_DO !== 10'b1010101010) begin
        errors++;
        $display("FAIL accum_f%0d: got %b expected %b", f, HypervectorOut_DO, 10'b1010101010);
      end
    end
    // Inverting with weight 16 moves +15/-15 to -1/+1; exposes the magnitude.
    step(1'b0, 1'b1, 1'b0, 10'b0101010101, 6'd16);
    checks++;
    if (HypervectorOut_DO !== 10'b0101010101) begin
      errors++;
      $display("FAIL accum_mag15: got %b expected %b", HypervectorOut_DO, 10'b0101010101);
    end
  endtask

  task automatic test_flip_and_tie();
    step(1'b0, 1'b1, 1'b1, 10'b1010101010, 6'd1);
    step(1'b0, 1'b1, 1'b0, 10'b0101010101, 6'd2);
    checks++;
    if (HypervectorOut_DO !== 10'b0101010101) begin
      errors++;
      $display("FAIL flip: got %b expected %b", HypervectorOut_DO, 10'b0101010101);
    end
    step(1'b0, 1'b1, 1'b1, 10'b1111111111, 6'd3);
    step(1'b0, 1'b1, 1'b0, 10'b0000000000, 6'd3);
    checks++;
    if (HypervectorOut_DO !== 10'b0000000000) begin
      errors++;
      $display("FAIL tie: got %b expected %b", HypervectorOut_DO, 10'b0);
    end
  endtask

  task automatic test_enable_hold();
    step(1'b0, 1'b1, 1'b1, 10'b1100110011, 6'd7);
    step(1'b0, 1'b0, 1'b1, 10'b0011001100, 6'd63);
    checks++;
    if (HypervectorOut_DO !== 10'b1100110011) begin
      errors++;
      $display("FAIL hold: got %b expected %b", HypervectorOut_DO, 10'b1100110011);
    end
    // +/-7 plus a -/+1 step must keep the old signs if the hold was real.
    step(1'b0, 1'b1, 1'b0, 10'b0011001100, 6'd1);
    checks++;
    if (HypervectorOut_DO !== 10'b1100110011) begin
      errors++;
      $display("FAIL hold_kept: got %b expected %b", HypervectorOut_DO, 10'b1100110011);
    end
    step(1'b0, 1'b1, 1'b1, 10'b1001011010, 6'd1);
    checks++;
    if (HypervectorOut_DO !== 10'b1001011010) begin
      errors++;
      $display("FAIL first_discard: got %b expected %b", HypervectorOut_DO, 10'b1001011010);
    end
    step(1'b0, 1'b1, 1'b1, 10'b1111111111, 6'd0);
    checks++;
    if (HypervectorOut_DO !== 10'b0000000000) begin
      errors++;
      $display("FAIL zero_load: got %b expected %b", HypervectorOut_DO, 10'b0);
    end
  endtask

  // 70 x 63 saturates at +4095; 4095 = 65 x 63, so exactly 65 down-steps tie.
  task automatic test_saturation();
    step(1'b0, 1'b1, 1'b1, 10'b1111111111, 6'd63);
    for (int n = 1; n < 70; n++) step(1'b0, 1'b1, 1'b0, 10'b1111111111, 6'd63);
    checks++;
    if (HypervectorOut_DO !== 10'b1111111111) begin
      errors++;
      $display("FAIL sat_pos: got %b expected %b", HypervectorOut_DO, 10'b1111111111);
    end
    for (int n = 0; n < 64; n++) step(1'b0, 1'b1, 1'b0, 10'b0000000000, 6'd63);
    checks++;
    if (HypervectorOut_DO !== 10'b1111111111) begin
      errors++;
      $display("FAIL sat_pos_64down: got %b expected %b", HypervectorOut_DO, 10'b1111111111);
    end
    step(1'b0, 1'b1, 1'b0, 10'b0000000000, 6'd63);
    checks++;
    if (HypervectorOut_DO !== 10'b0000000000) begin
      errors++;
      $display("FAIL sat_pos_65down: got %b expected %b", HypervectorOut_DO, 10'b0);
    end
    for (int n = 0; n < 70; n++) step(1'b0, 1'b1, 1'b0, 10'b0000000000, 6'd63);
    for (int n = 0; n < 65; n++) step(1'b0, 1'b1, 1'b0, 10'b1111111111, 6'd63);
    checks++;
    if (HypervectorOut_DO !== exp_out() || m_acc[0] != 0) begin
      errors++;
      $display("FAIL sat_neg: got %b expected %b", HypervectorOut_DO, exp_out());
    end
    step(1'b0, 1'b1, 1'b0, 10'b1111111111, 6'd63);
    step(1'b1, 1'b1, 1'b0, 10'b1111111111, 6'd63);
    checks++;
    if (HypervectorOut_DO !== 10'b0000000000) begin
      errors++;
      $display("FAIL reset_mid: got %b expected %b", HypervectorOut_DO, 10'b0);
    end
    step(1'b0, 1'b1, 1'b0, 10'b1100110011, 6'd5);
    checks++;
    if (HypervectorOut_DO !== 10'b1100110011) begin
      errors++;
      $display("FAIL post_reset_add: got %b expected %b", HypervectorOut_DO, 10'b1100110011);
    end
  endtask

  task automatic test_random();
    logic rst, en, first;
    logic [0:D-1] hv;
    logic [CW-1:0] f;
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 49) == 0);
      en    = ($urandom_range(0, 3) != 0);
      first = ($urandom_range(0, 11) == 0);
      hv    = D'($urandom);
      f     = (c % 40 < 20) ? CW'($urandom) : CW'($urandom_range(55, 63));
      step(rst, en, first, hv, f);
      checks++;
      if (HypervectorOut_DO !== exp_out()) begin
        errors++;
        $display("FAIL random c%0d: got %b expected %b", c, HypervectorOut_DO, exp_out());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < D; i++) m_acc[i] = 0;
    @(posedge Clk_CI);
    #1;
    test_reset();
    test_accumulate();
    test_flip_and_tie();
    test_enable_hold();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_spatial_accumulator
`default_nettype wire
